// File: rtl/mcpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_ctrl
// Purpose  : Multi-cycle Moore control unit for an RV32I core with a shared
//            instruction/data memory port. It sequences fetch, decode,
//            execute, memory and write-back. Memory accesses wait on
//            MIO_ready. A wait counter forces a sticky ERR state when the
//            bus stalls too long.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   OPcode[4:0] in   inst[6:2]
//   Fun3[2:0]   in   inst[14:12]
//   Fun7        in   inst[30]
//   zero        in   ALU zero flag
//   MIO_ready   in   memory/IO access completes this cycle
//   CPU_MIO     out  memory request
//   MemRW       out  1 = write
//   IorD        out  address select (0 = PC, 1 = ALUOut)
//   IRWrite     out  load IR and OldPC
//   PCWrite     out  load PC
//   PCSource    out  00 ALU, 01 ALUOut, 10 ALU with bit0 cleared
//   ALUSrc_A    out  00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrc_B    out  00 rs2, 01 const 4, 10 immediate
//   ALU_Control out  ALU operation code
//   ImmSel      out  immediate format (I/S/B/J/U)
//   MemtoReg    out  00 ALUOut, 01 MDR, 10 PC
//   RegWrite    out  register file write enable
//   state       out  current state (debug)
//   bus_err     out  sticky error indication, high only in ERR
// ============================================================================
module mcpu_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       CPU_MIO,
    output logic       MemRW,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrc_A,
    output logic [1:0] ALUSrc_B,
    output logic [3:0] ALU_Control,
    output logic [2:0] ImmSel,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_EX_MA    = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_LD    = 4'd7,
        S_WB_ALU   = 4'd8,
        S_EX_BR    = 4'd9,
        S_EX_JAL   = 4'd10,
        S_EX_JALR  = 4'd11,
        S_EX_LUI   = 4'd12,
        S_EX_AUIPC = 4'd13,
        S_ERR      = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic              waiting;
    logic              timeout_hit;
    logic              br_taken;
    logic              r_legal;
    logic [3:0]        r_op;

    // Unmasked decode; gated with rst at the ports.
    logic       mio, memrw, iord, irwrite, pcwrite, regwrite, err;
    logic [1:0] pcsrc, srca, srcb, memtoreg;
    logic [3:0] aluc;
    logic [2:0] immsel;

    // A wait cycle is any cycle in a memory-access state without MIO_ready.
    assign waiting = (state_q == S_IF || state_q == S_MEM_RD || state_q == S_MEM_WR)
                     && !MIO_ready;

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TO_W'(TIMEOUT)) && !MIO_ready;

    // R-type codes: {Fun7,Fun3}; only SUB and SRA are legal with Fun7 set.
    assign r_op    = {Fun7, Fun3};
    assign r_legal = !Fun7 || (r_op == ALU_SUB) || (r_op == ALU_SRA);

    // SUB gives zero on equality; SLT/SLTU give a nonzero result when less.
    always_comb begin
        br_taken = 1'b0;
        case (Fun3)
            3'b000:          br_taken = zero;
            3'b001:          br_taken = !zero;
            3'b100, 3'b110:  br_taken = !zero;
            3'b101, 3'b111:  br_taken = zero;
            default:         br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mio      = 1'b0;
        memrw    = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsrc    = 2'b00;
        srca     = 2'b00;
        srcb     = 2'b00;
        aluc     = ALU_ADD;
        immsel   = IMM_I;
        memtoreg = 2'b00;
        regwrite = 1'b0;
        err      = 1'b0;

        case (state_q)
            S_IF: begin
                mio  = 1'b1;
                srcb = 2'b01;
                if (MIO_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_ID;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_ID: begin
                // OldPC + imm lands in ALUOut for branch/JAL targets.
                srca = 2'b01;
                srcb = 2'b10;
                case (OPcode)
                    OP_STORE:         immsel = IMM_S;
                    OP_BRANCH:        immsel = IMM_B;
                    OP_JAL:           immsel = IMM_J;
                    OP_LUI, OP_AUIPC: immsel = IMM_U;
                    default:          immsel = IMM_I;
                endcase
                case (OPcode)
                    OP_R:               state_d = S_EX_R;
                    OP_I:               state_d = S_EX_I;
                    OP_LOAD, OP_STORE:  state_d = S_EX_MA;
                    OP_BRANCH:          state_d = S_EX_BR;
                    OP_JAL:             state_d = S_EX_JAL;
                    OP_JALR:            state_d = S_EX_JALR;
                    OP_LUI:             state_d = S_EX_LUI;
                    OP_AUIPC:           state_d = S_EX_AUIPC;
                    default:            state_d = S_ERR;
                endcase
            end
            S_EX_R: begin
                srca    = 2'b10;
                srcb    = 2'b00;
                aluc    = r_op;
                state_d = r_legal ? S_WB_ALU : S_ERR;
            end
            S_EX_I: begin
                // inst[30] is an immediate bit except for SRLI/SRAI.
                srca    = 2'b10;
                srcb    = 2'b10;
                aluc    = {Fun7 & (Fun3 == 3'b101), Fun3};
                state_d = S_WB_ALU;
            end
            S_EX_MA: begin
                srca    = 2'b10;
                srcb    = 2'b10;
                immsel  = (OPcode == OP_STORE) ? IMM_S : IMM_I;
                state_d = (OPcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mio  = 1'b1;
                iord = 1'b1;
                if (MIO_ready)        state_d = S_WB_LD;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_MEM_WR: begin
                mio   = 1'b1;
                iord  = 1'b1;
                memrw = 1'b1;
                if (MIO_ready)        state_d = S_IF;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_WB_LD: begin
                regwrite = 1'b1;
                memtoreg = 2'b01;
                state_d  = S_IF;
            end
            S_WB_ALU: begin
                regwrite = 1'b1;
                state_d  = S_IF;
            end
            S_EX_BR: begin
                srca = 2'b10;
                srcb = 2'b00;
                case (Fun3[2:1])
                    2'b10:   aluc = ALU_SLT;
                    2'b11:   aluc = ALU_SLTU;
                    default: aluc = ALU_SUB;
                endcase
                if (Fun3[2:1] == 2'b01) begin
                    state_d = S_ERR;
                end else begin
                    pcwrite = br_taken;
                    pcsrc   = 2'b01;
                    state_d = S_IF;
                end
            end
            S_EX_JAL: begin
                regwrite = 1'b1;
                memtoreg = 2'b10;
                pcwrite  = 1'b1;
                pcsrc    = 2'b01;
                state_d  = S_IF;
            end
            S_EX_JALR: begin
                // The PC still holds the link value when the RF write lands.
                srca     = 2'b10;
                srcb     = 2'b10;
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
                regwrite = 1'b1;
                memtoreg = 2'b10;
                state_d  = S_IF;
            end
            S_EX_LUI: begin
                srca    = 2'b11;
                srcb    = 2'b10;
                immsel  = IMM_U;
                state_d = S_WB_ALU;
            end
            S_EX_AUIPC: begin
                srca    = 2'b01;
                srcb    = 2'b10;
                immsel  = IMM_U;
                state_d = S_WB_ALU;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // Counter restarts on any state change and saturates so a disabled
    // timeout never wraps.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (waiting && (wait_cnt_q != {TO_W{1'b1}}))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IF;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Reset forces every output low, including the IF fetch request.
    assign CPU_MIO     = rst & mio;
    assign MemRW       = rst & memrw;
    assign IorD        = rst & iord;
    assign IRWrite     = rst & irwrite;
    assign PCWrite     = rst & pcwrite;
    assign RegWrite    = rst & regwrite;
    assign bus_err     = rst & err;
    assign PCSource    = rst ? pcsrc    : 2'b00;
    assign ALUSrc_A    = rst ? srca     : 2'b00;
    assign ALUSrc_B    = rst ? srcb     : 2'b00;
    assign MemtoReg    = rst ? memtoreg : 2'b00;
    assign ALU_Control = rst ? aluc     : 4'b0000;
    assign ImmSel      = rst ? immsel   : 3'b000;
    assign state       = rst ? state_q  : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcpu_ctrl
// Purpose  : Directed self-checking bench for mcpu_ctrl. It steps through
//            instruction classes, wait states, timeout, illegal decode and
//            asynchronous reset, with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcpu_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       zero;
    logic       MIO_ready;
    logic       CPU_MIO, MemRW, IorD, IRWrite, PCWrite, RegWrite, bus_err;
    logic [1:0] PCSource, ALUSrc_A, ALUSrc_B, MemtoReg;
    logic [3:0] ALU_Control, state;
    logic [2:0] ImmSel;

    int checks = 0;
    int errors = 0;

    logic [25:0] all_outs;
    assign all_outs = {CPU_MIO, MemRW, IorD, IRWrite, PCWrite, PCSource, ALUSrc_A,
                       ALUSrc_B, ALU_Control, ImmSel, MemtoReg, RegWrite, state, bus_err};

    mcpu_ctrl #(.TIMEOUT(15), .TO_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .OPcode      (OPcode),
        .Fun3        (Fun3),
        .Fun7        (Fun7),
        .zero        (zero),
        .MIO_ready   (MIO_ready),
        .CPU_MIO     (CPU_MIO),
        .MemRW       (MemRW),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCSource    (PCSource),
        .ALUSrc_A    (ALUSrc_A),
        .ALUSrc_B    (ALUSrc_B),
        .ALU_Control (ALU_Control),
        .ImmSel      (ImmSel),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .state       (state),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // IF with zero-wait memory, then check the ID cycle; returns in the
    // first execute-state cycle.
    task automatic fetch(input string nm, input logic [4:0] op, input logic [2:0] f3,
                         input logic f7, input logic [31:0] id_imm);
        OPcode = op; Fun3 = f3; Fun7 = f7; MIO_ready = 1'b1;
        #1;
        chk({nm, "_if_state"}, 32'(state), 0);
        chk({nm, "_if_irwrite"}, 32'(IRWrite), 1);
        cyc();
        chk({nm, "_id_state"}, 32'(state), 1);
        chk({nm, "_id_immsel"}, 32'(ImmSel), id_imm);
        cyc();
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b0;
        #1;
        chk({nm, "_rst_state"}, 32'(state), 0);
        chk({nm, "_rst_buserr"}, 32'(bus_err), 0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; MIO_ready = 1'b1; OPcode = '0; Fun3 = '0; Fun7 = 1'b0; zero = 1'b0;
        #3;
        chk("reset_all_zero", 32'(all_outs), 0);
        cyc();
        chk("reset_hold_state", 32'(state), 0);
        chk("reset_hold_mio", 32'(CPU_MIO), 0);
        rst = 1'b1;
        #1;
        chk("post_reset_mio", 32'(CPU_MIO), 1);
        chk("post_reset_srcb", 32'(ALUSrc_B), 1);

        // ADDI: 0,1,3,8
        fetch("addi", 5'b00100, 3'b000, 1'b0, 0);
        chk("addi_ex_state", 32'(state), 3);
        chk("addi_ex_alu", 32'(ALU_Control), 0);
        chk("addi_ex_regwrite", 32'(RegWrite), 0);
        cyc();
        chk("addi_wb_state", 32'(state), 8);
        chk("addi_wb_regwrite", 32'(RegWrite), 1);
        cyc();

        // ADD: 0,1,2,8
        fetch("add", 5'b01100, 3'b000, 1'b0, 0);
        chk("add_ex_state", 32'(state), 2);
        chk("add_ex_alu", 32'(ALU_Control), 0);
        chk("add_ex_srca", 32'(ALUSrc_A), 2);
        cyc();
        chk("add_wb_state", 32'(state), 8);
        cyc();

        fetch("sub", 5'b01100, 3'b000, 1'b1, 0);
        chk("sub_alu", 32'(ALU_Control), 'h8);
        cyc(); cyc();

        fetch("srai", 5'b00100, 3'b101, 1'b1, 0);
        chk("srai_alu", 32'(ALU_Control), 'hD);
        cyc(); cyc();

        fetch("sltiu", 5'b00100, 3'b011, 1'b0, 0);
        chk("sltiu_alu", 32'(ALU_Control), 'h3);
        cyc(); cyc();

        // ADDI with inst[30] set must still be ADD
        fetch("addi_neg", 5'b00100, 3'b000, 1'b1, 0);
        chk("addi_neg_alu", 32'(ALU_Control), 0);
        cyc(); cyc();

        // LW with 3 wait cycles in MEM_RD: 8 cycles total
        fetch("lw", 5'b00000, 3'b010, 1'b0, 0);
        chk("lw_ex_state", 32'(state), 4);
        MIO_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw_memrd_state", 32'(state), 5);
            chk("lw_memrd_mio", 32'(CPU_MIO), 1);
            chk("lw_memrd_iord", 32'(IorD), 1);
            cyc();
        end
        MIO_ready = 1'b1;
        #1;
        chk("lw_memrd_last_state", 32'(state), 5);
        chk("lw_memrd_last_memrw", 32'(MemRW), 0);
        cyc();
        chk("lw_wb_state", 32'(state), 7);
        chk("lw_wb_memtoreg", 32'(MemtoReg), 1);
        chk("lw_wb_regwrite", 32'(RegWrite), 1);
        cyc();
        chk("lw_back_to_if", 32'(state), 0);

        // SW
        fetch("sw", 5'b01000, 3'b010, 1'b0, 1);
        chk("sw_ex_immsel", 32'(ImmSel), 1);
        cyc();
        chk("sw_mem_state", 32'(state), 6);
        chk("sw_mem_memrw", 32'(MemRW), 1);
        cyc();
        chk("sw_back_to_if", 32'(state), 0);

        // Branches
        zero = 1'b1;
        fetch("beq", 5'b11000, 3'b000, 1'b0, 2);
        chk("beq_state", 32'(state), 9);
        chk("beq_alu", 32'(ALU_Control), 'h8);
        chk("beq_pcwrite", 32'(PCWrite), 1);
        chk("beq_pcsrc", 32'(PCSource), 1);
        cyc();
        chk("beq_back_to_if", 32'(state), 0);

        fetch("bne", 5'b11000, 3'b001, 1'b0, 2);
        chk("bne_pcwrite", 32'(PCWrite), 0);
        cyc();
        chk("bne_back_to_if", 32'(state), 0);

        zero = 1'b0;
        fetch("blt", 5'b11000, 3'b100, 1'b0, 2);
        chk("blt_alu", 32'(ALU_Control), 'h2);
        chk("blt_pcwrite", 32'(PCWrite), 1);
        cyc();

        fetch("bgeu", 5'b11000, 3'b111, 1'b0, 2);
        chk("bgeu_alu", 32'(ALU_Control), 'h3);
        chk("bgeu_pcwrite", 32'(PCWrite), 0);
        cyc();

        // JAL / JALR
        fetch("jal", 5'b11011, 3'b000, 1'b0, 3);
        chk("jal_state", 32'(state), 10);
        chk("jal_memtoreg", 32'(MemtoReg), 2);
        chk("jal_pcsrc", 32'(PCSource), 1);
        chk("jal_pcwrite", 32'(PCWrite), 1);
        cyc();
        chk("jal_back_to_if", 32'(state), 0);

        fetch("jalr", 5'b11001, 3'b000, 1'b0, 0);
        chk("jalr_state", 32'(state), 11);
        chk("jalr_pcsrc", 32'(PCSource), 2);
        chk("jalr_srca", 32'(ALUSrc_A), 2);
        chk("jalr_regwrite", 32'(RegWrite), 1);
        cyc();

        // LUI / AUIPC
        fetch("lui", 5'b01101, 3'b000, 1'b0, 4);
        chk("lui_state", 32'(state), 12);
        chk("lui_srca", 32'(ALUSrc_A), 3);
        cyc();
        chk("lui_wb_state", 32'(state), 8);
        cyc();

        fetch("auipc", 5'b00101, 3'b000, 1'b0, 4);
        chk("auipc_state", 32'(state), 13);
        chk("auipc_srca", 32'(ALUSrc_A), 1);
        cyc(); cyc();

        // 15 wait cycles in IF, ready arrives on the timeout cycle and wins
        OPcode = 5'b00100; Fun3 = 3'b000; Fun7 = 1'b0;
        MIO_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("wait_if_state", 32'(state), 0);
            cyc();
        end
        MIO_ready = 1'b1;
        #1;
        chk("wait_ready_wins_irwrite", 32'(IRWrite), 1);
        cyc();
        chk("wait_ready_wins_state", 32'(state), 1);
        cyc(); cyc(); cyc();

        // Reset during MEM_WR
        fetch("sw2", 5'b01000, 3'b010, 1'b0, 1);
        MIO_ready = 1'b0;
        cyc();
        chk("sw2_mem_memrw", 32'(MemRW), 1);
        rst = 1'b0;
        #1;
        chk("sw2_rst_memrw", 32'(MemRW), 0);
        chk("sw2_rst_mio", 32'(CPU_MIO), 0);
        chk("sw2_rst_state", 32'(state), 0);
        rst = 1'b1;
        #1;
        chk("sw2_rel_mio", 32'(CPU_MIO), 1);

        // Timeout: 16 IF cycles then ERR
        for (int i = 0; i < 16; i++) begin
            chk("to_if_state", 32'(state), 0);
            cyc();
        end
        chk("to_err_state", 32'(state), 15);
        chk("to_err_buserr", 32'(bus_err), 1);
        chk("to_err_mio", 32'(CPU_MIO), 0);
        MIO_ready = 1'b1;
        cyc();
        chk("to_err_sticky", 32'(state), 15);
        do_reset("to");

        // Illegal opcode
        fetch("illop", 5'b11111, 3'b000, 1'b0, 0);
        chk("illop_state", 32'(state), 15);
        chk("illop_buserr", 32'(bus_err), 1);
        do_reset("illop");

        // Illegal R-type {Fun7,Fun3} = 1001
        fetch("illr", 5'b01100, 3'b001, 1'b1, 0);
        chk("illr_ex_state", 32'(state), 2);
        cyc();
        chk("illr_err_state", 32'(state), 15);
        do_reset("illr");

        // Branch Fun3 = 010
        zero = 1'b1;
        fetch("illbr", 5'b11000, 3'b010, 1'b0, 2);
        chk("illbr_pcwrite", 32'(PCWrite), 0);
        cyc();
        chk("illbr_err_state", 32'(state), 15);
        do_reset("illbr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
